// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control path.
// The aluop codes match what alu_control decodes.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      ST_RESET    = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_ADDR = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_WB_MEM   = 4'd6,
      ST_EXEC_R   = 4'd7,
      ST_EXEC_I   = 4'd8,
      ST_WB_ALU   = 4'd9,
      ST_BRANCH   = 4'd10
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/branch_resolve.sv
// Conditional-branch decision from funct3 and the ALU flags.
// Purely combinational so a pipelined core can reuse it as-is.
module branch_resolve
   import multicycle_control_fsm_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      unique case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = !zero;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = !lt;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RISC-V datapath: sequences
// fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 mem_ready,
   input  logic                 zero,
   input  logic                 lt,
   output logic [1:0]           aluop,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic                 iord,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic                 mem_to_reg,
   output logic                 pc_src,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_e               state_q, state_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;
   logic                 taken;
   logic                 retire;

   branch_resolve u_branch_resolve (
      .funct3 (funct3),
      .zero   (zero),
      .lt     (lt),
      .taken  (taken)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      aluop      = ALUOP_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RS2;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      illegal    = 1'b0;
      unique case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = ST_DECODE;
         end
         // Branch target lands in ALUOut while the opcode is decoded.
         ST_DECODE: begin
            alu_src_b = SRCB_IMM;
            unique case (opcode)
               OP_R:              state_d = ST_EXEC_R;
               OP_I:              state_d = ST_EXEC_I;
               OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
               OP_BRANCH:         state_d = ST_BRANCH;
               default: begin
                  state_d = ST_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
         end
         ST_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_d = ST_WB_MEM;
         end
         ST_MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
         end
         ST_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = ST_FETCH;
            retire     = 1'b1;
         end
         ST_EXEC_R: begin
            alu_src_a = 1'b1;
            aluop     = ALUOP_R;
            state_d   = ST_WB_ALU;
         end
         ST_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_WB_ALU;
         end
         ST_WB_ALU: begin
            reg_write = 1'b1;
            state_d   = ST_FETCH;
            retire    = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            aluop     = ALUOP_BR;
            pc_src    = 1'b1;
            pc_write  = taken;
            state_d   = ST_FETCH;
            retire    = 1'b1;
         end
         default: state_d = ST_RESET;
      endcase
      instret_d = instret_q + INSTRET_W'(retire);
   end

   assign instret = instret_q;

endmodule
